// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch-address generator with a valid/ready fetch handshake.
// Optional return-address stack is built when the macro PC_RAS_EN is defined.
module pc_fetch_unit #(
    parameter int unsigned     WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_4180,
    parameter int unsigned     COUNT_W      = 32,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [WIDTH-1:0]   redirect_target,
    input  logic               exc_valid,
    input  logic               fetch_ready,
    output logic               fetch_valid,
    output logic [WIDTH-1:0]   fetch_pc,
    output logic [COUNT_W-1:0] fetch_count,
    output logic               misalign_err,
    input  logic               ras_push,
    input  logic [WIDTH-1:0]   ras_push_addr,
    input  logic               ras_pop,
    output logic [WIDTH-1:0]   ras_top,
    output logic               ras_empty,
    output logic               dbg_state_o
);

    // Handshake: fetch_pc is offered while fetch_valid=1; a fetch is accepted
    // (fire) on a rising edge where fetch_valid & fetch_ready are both 1.
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               misalign_q, misalign_d;
    logic               fire;

    assign fetch_valid  = (state_q == RUN);
    assign fire         = fetch_valid & fetch_ready;
    assign fetch_pc     = pc_q;
    assign fetch_count  = count_q;
    assign misalign_err = misalign_q;
    assign dbg_state_o  = state_q;

    always_comb begin
        state_d    = RUN;
        pc_d       = pc_q;
        count_d    = count_q;
        misalign_d = 1'b0;
        if (state_q == RUN) begin
            if (fire) begin
                count_d = count_q + COUNT_W'(1);
            end
            // Exceptions win over redirects; redirects ignore stall and fetch_ready.
            if (exc_valid) begin
                pc_d = EXC_VECTOR;
            end else if (redirect_valid) begin
                pc_d       = {redirect_target[WIDTH-1:2], 2'b00};
                misalign_d = |redirect_target[1:0];
            end else if (fire && !stall) begin
                pc_d = pc_q + WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned PW    = $clog2(RAS_DEPTH);
    localparam int unsigned OCC_W = PW + 1;

    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr_q, ras_ptr_d;
    logic [OCC_W-1:0] ras_occ_q, ras_occ_d;

    assign ras_empty = (ras_occ_q == '0);
    assign ras_top   = ras_empty ? RESET_VECTOR : ras_mem_q[ras_ptr_q];

    // ras_ptr_q indexes the top entry; a full stack overwrites its oldest slot.
    always_comb begin
        ras_mem_d = ras_mem_q;
        ras_ptr_d = ras_ptr_q;
        ras_occ_d = ras_occ_q;
        if (ras_push && (!ras_pop || ras_empty)) begin
            ras_ptr_d            = ras_ptr_q + PW'(1);
            ras_mem_d[ras_ptr_d] = ras_push_addr;
            if (ras_occ_q != OCC_W'(RAS_DEPTH)) begin
                ras_occ_d = ras_occ_q + OCC_W'(1);
            end
        end else if (ras_push && ras_pop) begin
            ras_mem_d[ras_ptr_q] = ras_push_addr;
        end else if (ras_pop && !ras_empty) begin
            ras_ptr_d = ras_ptr_q - PW'(1);
            ras_occ_d = ras_occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ras_ptr_q <= '0;
            ras_occ_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= RESET_VECTOR;
            end
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_occ_q <= ras_occ_d;
            ras_mem_q <= ras_mem_d;
        end
    end
`else
    logic unused_ras;
    assign unused_ras = ^{ras_push, ras_pop, ras_push_addr};
    assign ras_top    = RESET_VECTOR;
    assign ras_empty  = 1'b1;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit; RAS checks follow PC_RAS_EN.
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_valid;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_count;
    logic        misalign_err;
    logic        ras_push;
    logic [31:0] ras_push_addr;
    logic        ras_pop;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    pc_fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .exc_valid      (exc_valid),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_count    (fetch_count),
        .misalign_err   (misalign_err),
        .ras_push       (ras_push),
        .ras_push_addr  (ras_push_addr),
        .ras_pop        (ras_pop),
        .ras_top        (ras_top),
        .ras_empty      (ras_empty),
        .dbg_state_o    (dbg_state)
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        exc_valid = 1'b0; fetch_ready = 1'b1; ras_push = 1'b0; ras_pop = 1'b0;
        ras_push_addr = '0;
        repeat (3) tick();
        n_checks++; if (fetch_pc !== 32'h3000) $display("FAIL reset_pc: got %h want 00003000", fetch_pc); else n_pass++;
        n_checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fetch_valid); else n_pass++;
        n_checks++; if (fetch_count !== 32'd0) $display("FAIL reset_count: got %0d want 0", fetch_count); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign_err); else n_pass++;
        n_checks++; if (ras_empty !== 1'b1 || ras_top !== 32'h3000) $display("FAIL reset_ras: got empty=%b top=%h want 1/00003000", ras_empty, ras_top); else n_pass++;
        n_checks++; if (dbg_state !== 1'b0) $display("FAIL reset_state: got %b want 0", dbg_state); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h3000; exp_pc[1] = 32'h3004; exp_pc[2] = 32'h3008;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_pc !== exp_pc[i] || fetch_count !== 32'(i))
                $display("FAIL seq_%0d: got v=%b pc=%h cnt=%0d want v=1 pc=%h cnt=%0d",
                         i, fetch_valid, fetch_pc, fetch_count, exp_pc[i], i);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (fetch_pc !== 32'h3008 || fetch_count !== 32'(3 + i))
                $display("FAIL stall_%0d: got pc=%h cnt=%0d want pc=00003008 cnt=%0d",
                         i, fetch_pc, fetch_count, 3 + i);
            else n_pass++;
        end
        stall = 1'b0; fetch_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (fetch_pc !== 32'h3008 || fetch_count !== 32'd5)
                $display("FAIL notready_%0d: got pc=%h cnt=%0d want pc=00003008 cnt=5",
                         i, fetch_pc, fetch_count);
            else n_pass++;
        end
        fetch_ready = 1'b1;
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h3100;
        tick();
        n_checks++; if (fetch_pc !== 32'h3100 || fetch_count !== 32'd6 || misalign_err !== 1'b0)
            $display("FAIL redir_stall: got pc=%h cnt=%0d mis=%b want 00003100/6/0", fetch_pc, fetch_count, misalign_err);
        else n_pass++;
        exc_valid = 1'b1; redirect_target = 32'h3101;
        tick();
        n_checks++; if (fetch_pc !== 32'h4180 || fetch_count !== 32'd7 || misalign_err !== 1'b0)
            $display("FAIL exc_prio: got pc=%h cnt=%0d mis=%b want 00004180/7/0", fetch_pc, fetch_count, misalign_err);
        else n_pass++;
        stall = 1'b0; exc_valid = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_target = 32'h3203;
        tick();
        n_checks++; if (fetch_pc !== 32'h3200 || misalign_err !== 1'b1 || fetch_count !== 32'd8)
            $display("FAIL misalign_set: got pc=%h mis=%b cnt=%0d want 00003200/1/8", fetch_pc, misalign_err, fetch_count);
        else n_pass++;
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (fetch_pc !== 32'h3204 || misalign_err !== 1'b0 || fetch_count !== 32'd9)
            $display("FAIL misalign_clr: got pc=%h mis=%b cnt=%0d want 00003204/0/9", fetch_pc, misalign_err, fetch_count);
        else n_pass++;
        fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h5000;
        tick();
        n_checks++; if (fetch_pc !== 32'h5000 || fetch_count !== 32'd9)
            $display("FAIL redir_notready: got pc=%h cnt=%0d want 00005000/9", fetch_pc, fetch_count);
        else n_pass++;
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (fetch_pc !== 32'h5000 || fetch_count !== 32'd9)
            $display("FAIL hold_notready: got pc=%h cnt=%0d want 00005000/9", fetch_pc, fetch_count);
        else n_pass++;
        fetch_ready = 1'b1;
    endtask

    task automatic test_ras();
`ifdef PC_RAS_EN
        logic [31:0] exp_top [4];
        exp_top[0] = 32'h400; exp_top[1] = 32'h300; exp_top[2] = 32'h200; exp_top[3] = 32'h3000;
        ras_push = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ras_push_addr = 32'(i * 32'h100);
            tick();
        end
        n_checks++; if (ras_top !== 32'h500 || ras_empty !== 1'b0)
            $display("FAIL ras_push5: got top=%h empty=%b want 00000500/0", ras_top, ras_empty);
        else n_pass++;
        ras_push = 1'b0; ras_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (ras_top !== exp_top[i] || ras_empty !== (i == 3))
                $display("FAIL ras_pop_%0d: got top=%h empty=%b want %h/%b", i, ras_top, ras_empty, exp_top[i], (i == 3));
            else n_pass++;
        end
        tick();
        n_checks++; if (ras_top !== 32'h3000 || ras_empty !== 1'b1)
            $display("FAIL ras_pop_empty: got top=%h empty=%b want 00003000/1", ras_top, ras_empty);
        else n_pass++;
        ras_pop = 1'b0; ras_push = 1'b1; ras_push_addr = 32'h600;
        tick();
        ras_pop = 1'b1; ras_push_addr = 32'h700;
        tick();
        n_checks++; if (ras_top !== 32'h700 || ras_empty !== 1'b0)
            $display("FAIL ras_pushpop: got top=%h empty=%b want 00000700/0", ras_top, ras_empty);
        else n_pass++;
        ras_push = 1'b0;
        tick();
        n_checks++; if (ras_empty !== 1'b1)
            $display("FAIL ras_pushpop_occ: got empty=%b want 1", ras_empty);
        else n_pass++;
        ras_pop = 1'b0;
`else
        ras_push = 1'b1; ras_push_addr = 32'h1234;
        repeat (2) tick();
        ras_push = 1'b0;
        n_checks++; if (ras_top !== 32'h3000 || ras_empty !== 1'b1)
            $display("FAIL ras_disabled: got top=%h empty=%b want 00003000/1", ras_top, ras_empty);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_midrun();
        ras_push = 1'b1; ras_push_addr = 32'h800;
        tick();
        ras_push = 1'b0;
        reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h6000;
        tick();
        n_checks++;
        if (fetch_pc !== 32'h3000 || fetch_count !== 32'd0 || fetch_valid !== 1'b0 ||
            ras_empty !== 1'b1 || ras_top !== 32'h3000 || misalign_err !== 1'b0)
            $display("FAIL reset_midrun: got pc=%h cnt=%0d v=%b empty=%b top=%h mis=%b want 00003000/0/0/1/00003000/0",
                     fetch_pc, fetch_count, fetch_valid, ras_empty, ras_top, misalign_err);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (fetch_pc !== 32'h3000 || fetch_valid !== 1'b1 || fetch_count !== 32'd0 || dbg_state !== 1'b1)
            $display("FAIL boot_ignores_redirect: got pc=%h v=%b cnt=%0d st=%b want 00003000/1/0/1",
                     fetch_pc, fetch_valid, fetch_count, dbg_state);
        else n_pass++;
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misalign();
        test_ras();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
